mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of retired-instruction counter instret.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 inst  input  32  instruction register contents, stable from DECODE until next FETCH.
REQ-005 imem_ack  input  1  instruction memory completes the read in the cycle it is high.
REQ-006 dmem_ack  input  1  data memory completes the access in the cycle it is high.
REQ-007 br_taken  input  1  branch compare result from ALU, valid in EXEC.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_we  output  1  load inst register.
REQ-010 pc_we  output  1  update PC.
REQ-011 pc_sel  output  1  0 = PC+4, 1 = PC+imm.
REQ-012 alu_src_imm  output  1  ALU operand B = imm when 1, else rs2.
REQ-013 alu_op  output  4  {inst[30], inst[14:12]} for OP/OP-IMM; ADD (4'b0000) for LOAD/STORE; SUB (4'b1000) for BRANCH.
REQ-014 dmem_req / dmem_we  output  1 each  data access request / write enable.
REQ-015 rf_we  output  1  register file write; wb_sel output 1: 0 = ALU, 1 = memory.
REQ-016 state  output  3  current FSM state code.
REQ-017 instret  output  RETIRE_W  retired-instruction count.

Function
REQ-018 States, encoded: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-019 FETCH: imem_req=1; on imem_ack, ir_we=1 same cycle, go to DECODE; else hold, imem_req stays high.
REQ-020 DECODE: one cycle, no outputs except alu_op/alu_src_imm pre-driven; go to EXEC.
REQ-021 EXEC by inst[6:2]: 00000 LOAD or 01000 STORE -> MEM; 00100 OP-IMM or 01100 OP -> WB; 11000 BRANCH -> FETCH with pc_we=1, pc_sel=br_taken.
REQ-022 MEM: dmem_req=1, dmem_we=1 only for STORE; on dmem_ack, LOAD -> WB, STORE -> FETCH with pc_we=1, pc_sel=0; without ack, hold with request held.
REQ-023 WB: rf_we=1, wb_sel=1 for LOAD else 0, pc_we=1, pc_sel=0; go to FETCH.
REQ-024 alu_src_imm=1 for LOAD, STORE, OP-IMM; 0 for OP, BRANCH.
REQ-025 Retire = cycle pc_we=1; instret increments by 1 in that cycle, wraps from all-ones to 0 without flag.
REQ-026 Unsupported opcode in EXEC: behaviour per REQ-032/033.
REQ-027 Ack asserted in a state that does not request it is ignored; no state change.
REQ-028 All outputs not listed as active in a state are 0; outputs are decoded combinationally from state and inst.

Reset
REQ-029 rst high: state=FETCH immediately, instret=0, all strobes 0 (imem_req asserted only after rst low).
REQ-030 Reset mid-access (MEM or FETCH pending): request dropped immediately, no retire counted.
REQ-031 First fetch begins in first clk edge cycle after rst deasserts.

Configuration
REQ-032 MC_CTRL_ILLEGAL_TRAP_EN defined: unsupported opcode -> TRAP, no pc_we, stays in TRAP until reset; output trap (1 bit) high in TRAP.
REQ-033 Macro undefined: unsupported opcode treated as NOP -> FETCH with pc_we=1, pc_sel=0, counted as retired; no trap port, TRAP code unused.

Structure
REQ-034 Shared package holds state encoding enum, opcode constants (LOAD, OP_IMM, STORE, BRANCH, OP) and ALU op codes ADD/SUB.
REQ-035 Single sub-module mc_ctrl_dec: combinational opcode class and alu_op decode from inst; FSM and counter stay in mc_ctrl.

Verification
REQ-036 addi (0x00500093), imem_ack after 2 cycles -> FETCH(3 cycles) DECODE EXEC WB, rf_we=1, wb_sel=0, instret 0->1.
REQ-037 lw (0x00002083), dmem_ack after 3 cycles -> MEM held 4 cycles dmem_we=0, then WB wb_sel=1, instret+1.
REQ-038 beq (0x00000463), br_taken=1 -> EXEC pc_we=1 pc_sel=1, no rf_we; br_taken=0 -> pc_sel=0.
REQ-039 sw (0x00102023) with rst pulsed during MEM -> state=0, dmem_req=0 same cycle, instret unchanged.
REQ-040 opcode 0x0000007F -> with macro: TRAP, trap=1, instret frozen; without: FETCH, instret+1.
REQ-041 instret preset near wrap (RETIRE_W=4, 15 retires then one more) -> instret 15->0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg : state encoding, opcode classes and ALU op constants    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD    = 3'd0,
      CLS_STORE   = 3'd1,
      CLS_OP_IMM  = 3'd2,
      CLS_OP      = 3'd3,
      CLS_BRANCH  = 3'd4,
      CLS_ILLEGAL = 3'd5
   } op_class_t;

   localparam logic [4:0] C_OPC_LOAD   = 5'b00000;
   localparam logic [4:0] C_OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] C_OPC_STORE  = 5'b01000;
   localparam logic [4:0] C_OPC_OP     = 5'b01100;
   localparam logic [4:0] C_OPC_BRANCH = 5'b11000;

   localparam logic [3:0] C_ALU_ADD = 4'b0000;
   localparam logic [3:0] C_ALU_SUB = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_dec : combinational opcode class and ALU control decode      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mc_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output logic [2:0]  op_class,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm
);

   logic w_unused_bits;
   assign w_unused_bits = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};

   always_comb begin
      op_class    = CLS_ILLEGAL;
      alu_op      = C_ALU_ADD;
      alu_src_imm = 1'b0;
      case (inst[6:2])
         C_OPC_LOAD: begin
            op_class    = CLS_LOAD;
            alu_src_imm = 1'b1;
         end
         C_OPC_STORE: begin
            op_class    = CLS_STORE;
            alu_src_imm = 1'b1;
         end
         C_OPC_OP_IMM: begin
            op_class    = CLS_OP_IMM;
            alu_op      = {inst[30], inst[14:12]};
            alu_src_imm = 1'b1;
         end
         C_OPC_OP: begin
            op_class    = CLS_OP;
            alu_op      = {inst[30], inst[14:12]};
         end
         C_OPC_BRANCH: begin
            op_class    = CLS_BRANCH;
            alu_op      = C_ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl : multi-cycle CPU control FSM with retired-instruction count |
// | Option  : MC_CTRL_ILLEGAL_TRAP_EN -> unsupported opcode traps        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         inst,
   input  logic                imem_ack,
   input  logic                dmem_ack,
   input  logic                br_taken,
   output logic                imem_req,
   output logic                ir_we,
   output logic                pc_we,
   output logic                pc_sel,
   output logic                alu_src_imm,
   output logic [3:0]          alu_op,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                rf_we,
   output logic                wb_sel,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] instret
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                trap
`endif
);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          w_op_class;
   logic [3:0]          w_alu_op;
   logic                w_alu_src_imm;
   logic [RETIRE_W-1:0] r_instret;

   mc_ctrl_dec u_dec (
      .inst        (inst),
      .op_class    (w_op_class),
      .alu_op      (w_alu_op),
      .alu_src_imm (w_alu_src_imm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Strobes are held low while rst is high so a pending access drops at once
   always_comb begin
      w_next      = r_state;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = 4'b0000;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      trap        = 1'b0;
`endif
      if (!rst) begin
         case (r_state)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we  = 1'b1;
                  w_next = ST_DECODE;
               end
            end
            ST_DECODE: begin
               alu_op      = w_alu_op;
               alu_src_imm = w_alu_src_imm;
               w_next      = ST_EXEC;
            end
            ST_EXEC: begin
               alu_op      = w_alu_op;
               alu_src_imm = w_alu_src_imm;
               case (w_op_class)
                  CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                  CLS_OP_IMM, CLS_OP:  w_next = ST_WB;
                  CLS_BRANCH: begin
                     pc_we  = 1'b1;
                     pc_sel = br_taken;
                     w_next = ST_FETCH;
                  end
                  default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                     w_next = ST_TRAP;
`else
                     pc_we  = 1'b1;
                     w_next = ST_FETCH;
`endif
                  end
               endcase
            end
            ST_MEM: begin
               alu_op      = w_alu_op;
               alu_src_imm = w_alu_src_imm;
               dmem_req    = 1'b1;
               dmem_we     = (w_op_class == CLS_STORE);
               if (dmem_ack) begin
                  if (w_op_class == CLS_LOAD) begin
                     w_next = ST_WB;
                  end else begin
                     pc_we  = 1'b1;
                     w_next = ST_FETCH;
                  end
               end
            end
            ST_WB: begin
               alu_op      = w_alu_op;
               alu_src_imm = w_alu_src_imm;
               rf_we       = 1'b1;
               wb_sel      = (w_op_class == CLS_LOAD);
               pc_we       = 1'b1;
               w_next      = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               trap = 1'b1;
`else
               w_next = ST_FETCH;
`endif
            end
            default: w_next = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instret <= '0;
      end else if (pc_we) begin
         r_instret <= r_instret + RETIRE_W'(1);
      end
   end

   assign state   = r_state;
   assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_ctrl : randomized self-checking bench for mc_ctrl              |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        imem_ack, dmem_ack, br_taken;

   logic        imem_req, ir_we, pc_we, pc_sel, alu_src_imm, dmem_req, dmem_we, rf_we, wb_sel;
   logic [3:0]  alu_op;
   logic [2:0]  state;
   logic [31:0] instret;

   logic        imem_req_w, ir_we_w, pc_we_w, pc_sel_w, alu_src_imm_w, dmem_req_w, dmem_we_w, rf_we_w, wb_sel_w;
   logic [3:0]  alu_op_w;
   logic [2:0]  state_w;
   logic [3:0]  instret_w;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic        trap, trap_w;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_instret;

   mc_ctrl #(.RETIRE_W(32)) dut (
      .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .instret(instret)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , .trap(trap)
`endif
   );

   mc_ctrl #(.RETIRE_W(4)) dut_w (
      .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .br_taken(br_taken), .imem_req(imem_req_w), .ir_we(ir_we_w), .pc_we(pc_we_w),
      .pc_sel(pc_sel_w), .alu_src_imm(alu_src_imm_w), .alu_op(alu_op_w), .dmem_req(dmem_req_w),
      .dmem_we(dmem_we_w), .rf_we(rf_we_w), .wb_sel(wb_sel_w), .state(state_w), .instret(instret_w)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , .trap(trap_w)
`endif
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_instret = 32'd0;
   endtask

   // Runs one instruction from FETCH until it retires and scores it against
   // the instruction's expected transaction profile.
   task automatic exec_instr(input logic [31:0] ins, input int idly, input int ddly,
                             input logic br, input string nm);
      int   nf = 0, nd = 0, nwe = 0, nrf = 0, nir = 0, ncyc = 0;
      logic done = 1'b0, wbs = 1'b0, psel = 1'b0, got_exec = 1'b0, asrc = 1'b0;
      logic [3:0] aop = 4'h0;
      logic is_ld, is_st, is_ops, is_br, legal, e_asrc;
      logic [3:0] e_aop;
      int   e_mem, e_rf, e_cyc;
      is_ld  = (ins[6:2] == 5'b00000);
      is_st  = (ins[6:2] == 5'b01000);
      is_ops = (ins[6:2] == 5'b00100) || (ins[6:2] == 5'b01100);
      is_br  = (ins[6:2] == 5'b11000);
      legal  = is_ld | is_st | is_ops | is_br;
      e_aop  = is_ops ? {ins[30], ins[14:12]} : (is_br ? 4'b1000 : 4'b0000);
      e_asrc = is_ld | is_st | (ins[6:2] == 5'b00100);
      e_mem  = (is_ld | is_st) ? ddly + 1 : 0;
      e_rf   = (is_ld | is_ops) ? 1 : 0;
      e_cyc  = idly + 1 + 2 + e_mem + e_rf;
      inst = ins;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk); #1;
         if (imem_req) begin imem_ack = (nf == idly); nf++; end
         else imem_ack = 1'($urandom);
         if (dmem_req) begin dmem_ack = (nd == ddly); nd++; end
         else dmem_ack = 1'($urandom);
         br_taken = (state == 3'd2) ? br : 1'($urandom);
         #1;
         ncyc++;
         if (ir_we) nir++;
         if (dmem_we) nwe++;
         if (rf_we) begin nrf++; wbs = wb_sel; end
         if (state == 3'd2 && !got_exec) begin got_exec = 1'b1; aop = alu_op; asrc = alu_src_imm; end
         if (pc_we) begin done = 1'b1; psel = pc_sel; end
      end
      @(posedge clk); #1;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      exp_instret = exp_instret + 32'd1;
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL %s retire_timeout got %0b want 1", nm, done); end
      tests++; if (ncyc != e_cyc) begin fails++; $display("FAIL %s cycles got %0d want %0d", nm, ncyc, e_cyc); end
      tests++; if (nf != idly + 1) begin fails++; $display("FAIL %s fetch_cycles got %0d want %0d", nm, nf, idly + 1); end
      tests++; if (nir != 1) begin fails++; $display("FAIL %s ir_we_count got %0d want 1", nm, nir); end
      tests++; if (nd != e_mem) begin fails++; $display("FAIL %s mem_cycles got %0d want %0d", nm, nd, e_mem); end
      tests++; if (nwe != (is_st ? e_mem : 0)) begin fails++; $display("FAIL %s dmem_we_cycles got %0d want %0d", nm, nwe, is_st ? e_mem : 0); end
      tests++; if (nrf != e_rf) begin fails++; $display("FAIL %s rf_we_count got %0d want %0d", nm, nrf, e_rf); end
      if (e_rf == 1) begin
         tests++; if (wbs !== is_ld) begin fails++; $display("FAIL %s wb_sel got %0b want %0b", nm, wbs, is_ld); end
      end
      tests++; if (psel !== (is_br & br)) begin fails++; $display("FAIL %s pc_sel got %0b want %0b", nm, psel, is_br & br); end
      if (legal) begin
         tests++; if (aop !== e_aop) begin fails++; $display("FAIL %s alu_op got %h want %h", nm, aop, e_aop); end
         tests++; if (asrc !== e_asrc) begin fails++; $display("FAIL %s alu_src_imm got %0b want %0b", nm, asrc, e_asrc); end
      end
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL %s end_state got %0d want 0", nm, state); end
      tests++; if (instret !== exp_instret) begin fails++; $display("FAIL %s instret got %0d want %0d", nm, instret, exp_instret); end
      tests++; if (instret_w !== exp_instret[3:0]) begin fails++; $display("FAIL %s instret4 got %0d want %0d", nm, instret_w, exp_instret[3:0]); end
   endtask

   task automatic test_reset();
      rst = 1'b1; inst = 32'h00500093; imem_ack = 1'b1; dmem_ack = 1'b1; br_taken = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
      tests++; if ({imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we} !== 6'b0) begin
         fails++; $display("FAIL reset_strobes got %b want 000000", {imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we}); end
      tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
      imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
      rst = 1'b0; #1;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_fetch imem_req got %0b want 1", imem_req); end
      exp_instret = 32'd0;
   endtask

   task automatic test_reset_mid_access();
      int guard = 0;
      inst = 32'h00102023;
      while (state !== 3'd3 && guard < 20) begin
         @(negedge clk); #1;
         imem_ack = imem_req;
         guard++;
      end
      @(negedge clk); #1;
      imem_ack = 1'b0;
      tests++; if (dmem_req !== 1'b1 || state !== 3'd3) begin
         fails++; $display("FAIL mid_mem_setup state got %0d want 3", state); end
      rst = 1'b1; #1;
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL mid_mem_rst state got %0d want 0", state); end
      tests++; if ({dmem_req, dmem_we} !== 2'b00) begin fails++; $display("FAIL mid_mem_rst dmem got %b want 00", {dmem_req, dmem_we}); end
      tests++; if (instret !== exp_instret) begin fails++; $display("FAIL mid_mem_rst instret got %0d want %0d", instret, exp_instret); end
      @(negedge clk); rst = 1'b0; #1;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fetch_pending imem_req got %0b want 1", imem_req); end
      rst = 1'b1; #1;
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fetch_rst imem_req got %0b want 0", imem_req); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_directed();
      exec_instr(32'h00500093, 2, 0, 1'b0, "addi");
      exec_instr(32'h00002083, 0, 3, 1'b0, "lw");
      exec_instr(32'h00000463, 1, 0, 1'b1, "beq_taken");
      exec_instr(32'h00000463, 0, 0, 1'b0, "beq_not_taken");
      exec_instr(32'h00102023, 1, 2, 1'b0, "sw");
   endtask

   task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      int guard = 0;
      inst = 32'h0000007F;
      while (state !== 3'd5 && guard < 20) begin
         @(negedge clk); #1;
         imem_ack = imem_req;
         guard++;
      end
      imem_ack = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      tests++; if (state !== 3'd5) begin fails++; $display("FAIL trap_state got %0d want 5", state); end
      tests++; if (trap !== 1'b1) begin fails++; $display("FAIL trap_flag got %0b want 1", trap); end
      tests++; if (pc_we !== 1'b0) begin fails++; $display("FAIL trap_pc_we got %0b want 0", pc_we); end
      tests++; if (instret !== exp_instret) begin fails++; $display("FAIL trap_instret got %0d want %0d", instret, exp_instret); end
      do_reset();
`else
      exec_instr(32'h0000007F, 1, 0, 1'b0, "illegal_nop");
`endif
   endtask

   task automatic test_random();
      logic [4:0]  opcs [7];
      logic [31:0] ins;
      int          nops;
      opcs = '{5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11000, 5'b11111, 5'b00101};
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      nops = 5;
`else
      nops = 7;
`endif
      for (int i = 0; i < 40; i++) begin
         ins      = $urandom;
         ins[6:2] = opcs[$urandom_range(nops - 1, 0)];
         ins[1:0] = 2'b11;
         exec_instr(ins, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom), "random");
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) exec_instr(32'h00500093, 0, 0, 1'b0, "wrap_fill");
      tests++; if (instret_w !== 4'd15) begin fails++; $display("FAIL wrap_pre got %0d want 15", instret_w); end
      exec_instr(32'h00500093, 0, 0, 1'b0, "wrap_last");
      tests++; if (instret_w !== 4'd0) begin fails++; $display("FAIL wrap_post got %0d want 0", instret_w); end
      tests++; if (instret !== 32'd16) begin fails++; $display("FAIL wrap_wide got %0d want 16", instret); end
   endtask

   initial begin
      exp_instret = 32'd0;
      test_reset();
      test_reset_mid_access();
      test_directed();
      test_illegal();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
